// File: rtl/yolo_stream_defs.sv
`default_nettype none
// =============================================================================
// yolo_stream_defs : shared stream defaults, beat layout and width helpers
// Rev 1.0
// =============================================================================
package yolo_stream_defs;

    localparam int TBITS_DEF = 64;
    localparam int TBYTE_DEF = TBITS_DEF / 8;

    // Beat layout as stored in the buffer, MSB first.
    typedef struct packed {
        logic                 user;
        logic                 last;
        logic [TBYTE_DEF-1:0] strb;
        logic [TBITS_DEF-1:0] data;
    } beat_t;

    function automatic int beat_width(input int tbits, input int tbyte);
        return tbits + tbyte + 2;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_sync_fifo.sv
`default_nettype none
// =============================================================================
// stream_sync_fifo : DEPTH x WIDTH buffer, registered FWFT head, level, full_n
// Rev 1.0
// =============================================================================
module stream_sync_fifo
    import yolo_stream_defs::*;
#(
    parameter int WIDTH = 74,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [WIDTH-1:0]      din_i,
    output logic                  full_n_o,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      dout_o,
    output logic [clog2(DEPTH):0] level_o
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_n_q, valid_q;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             accept, xfer;

    assign accept = wr_i & full_n_q;
    assign xfer   = valid_q & ready_i;

    always_comb begin
        wptr_d  = wptr_q + AW'(accept);
        rptr_d  = rptr_q + AW'(xfer);
        level_d = level_q;
        case ({accept, xfer})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // The new head is the beat being written only when it becomes the sole entry.
        dout_d = (accept && (wptr_q == rptr_d)) ? din_i : mem_q[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            full_n_q <= 1'b0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            full_n_q <= (level_d < LW'(DEPTH));
            valid_q  <= (level_d != '0);
            dout_q   <= dout_d;
        end
    end

    assign full_n_o = full_n_q;
    assign valid_o  = valid_q;
    assign dout_o   = dout_q;
    assign level_o  = level_q;

endmodule
`default_nettype wire

// File: rtl/osif_axis_tx.sv
`default_nettype none
// =============================================================================
// osif_axis_tx : core write port to AXI4-Stream S2MM master with TLAST tagging
// Rev 1.0
// =============================================================================
module osif_axis_tx
    import yolo_stream_defs::*;
#(
    parameter int TBITS = TBITS_DEF,
    parameter int TBYTE = TBYTE_DEF,
    parameter int DEPTH = 16,
    parameter int CNTW  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [TBITS-1:0]      osif_data_din,
    input  logic [TBYTE-1:0]      osif_strb_din,
    input  logic                  osif_last_din,
    input  logic                  osif_user_din,
    input  logic                  osif_write,
    output logic                  osif_full_n,
    input  logic [CNTW-1:0]       pkt_beats,
    output logic                  M_AXIS_S2MM_TVALID,
    input  logic                  M_AXIS_S2MM_TREADY,
    output logic [TBITS-1:0]      M_AXIS_S2MM_TDATA,
    output logic [TBYTE-1:0]      M_AXIS_S2MM_TKEEP,
    output logic                  M_AXIS_S2MM_TLAST,
    output logic                  M_AXIS_S2MM_TUSER,
    output logic [clog2(DEPTH):0] fifo_level,
    output logic                  pkt_done
);

    localparam int BW = beat_width(TBITS, TBYTE);

    logic [CNTW-1:0] wcnt_q, wcnt_d;
    logic            accept, last_tag, pkt_done_q;
    logic [BW-1:0]   fifo_dout;

    assign accept = osif_write & osif_full_n;

    always_comb begin
        last_tag = osif_last_din | ((pkt_beats != '0) && (wcnt_q == pkt_beats - CNTW'(1)));
        wcnt_d   = wcnt_q;
        if (accept) wcnt_d = last_tag ? '0 : wcnt_q + CNTW'(1);
    end

    stream_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_i     (osif_write),
        .din_i    ({osif_user_din, last_tag, osif_strb_din, osif_data_din}),
        .full_n_o (osif_full_n),
        .ready_i  (M_AXIS_S2MM_TREADY),
        .valid_o  (M_AXIS_S2MM_TVALID),
        .dout_o   (fifo_dout),
        .level_o  (fifo_level)
    );

    assign {M_AXIS_S2MM_TUSER, M_AXIS_S2MM_TLAST, M_AXIS_S2MM_TKEEP, M_AXIS_S2MM_TDATA} = fifo_dout;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wcnt_q     <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            pkt_done_q <= M_AXIS_S2MM_TVALID & M_AXIS_S2MM_TREADY & M_AXIS_S2MM_TLAST;
        end
    end

    assign pkt_done = pkt_done_q;

    // The beat interval may only be retuned on a packet boundary.
    a_pkt_beats_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (wcnt_q != '0) |-> $stable(pkt_beats));

endmodule
`default_nettype wire
